// File: rtl/output_buffer_ctrl_if.sv
// rtl/output_buffer_ctrl_if.sv - tile control, fill, buffer and external-stream signals of the output buffer sequencer
// master: tile issuer, array, buffer and consumer side; slave: the controller.
interface output_buffer_ctrl_if #(
   parameter int AW = 4,
   parameter int DW = 32
);
   logic          start;
   logic [AW:0]   tile_len;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          res_ready;
   logic [DW-1:0] buf_store_data;
   logic [AW-1:0] buf_store_addr;
   logic          buf_store_en;
   logic [AW-1:0] buf_send_addr;
   logic          buf_send_en;
   logic [DW-1:0] buf_res;
   logic          ext_valid;
   logic [DW-1:0] ext_data;
   logic          ext_ready;
   logic          busy;
   logic          tile_done;

   modport master (
      output start, tile_len, res_valid, res_data, buf_res, ext_ready,
      input  res_ready, buf_store_data, buf_store_addr, buf_store_en,
             buf_send_addr, buf_send_en, ext_valid, ext_data, busy, tile_done
   );

   modport slave (
      input  start, tile_len, res_valid, res_data, buf_res, ext_ready,
      output res_ready, buf_store_data, buf_store_addr, buf_store_en,
             buf_send_addr, buf_send_en, ext_valid, ext_data, busy, tile_done
   );
endinterface

// File: rtl/output_buffer_ctrl.sv
// rtl/output_buffer_ctrl.sv - fill/drain sequencer for the output result buffer
// Optional status outputs (occupancy, proto_err) under OUTPUT_BUFFER_CTRL_STATUS_EN.
module output_buffer_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   output_buffer_ctrl_if.slave  bus
`ifdef OUTPUT_BUFFER_CTRL_STATUS_EN
   ,
   output logic [AW:0]          occupancy,
   output logic                 proto_err
`endif
);
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
   localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] rd_issued_q, rd_issued_d;
   logic [AW:0] len_q, len_d;
   logic        ext_valid_q, ext_valid_d;
   logic        tile_done_q, tile_done_d;
   logic        busy_q, busy_d;
   logic        res_ready_c, store_en_c, send_en_c, hs_c;
   logic [AW:0] avail_c;
`ifdef OUTPUT_BUFFER_CTRL_STATUS_EN
   logic        proto_err_q, proto_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_issued_d = rd_issued_q;
      len_d       = len_q;

      res_ready_c = (state_q == ACTIVE) && (wr_ptr_q < len_q);
      store_en_c  = bus.res_valid && res_ready_c;
      // Only entries written on an earlier edge are readable, so a read never races its own write.
      avail_c     = wr_ptr_q - rd_issued_q;
      send_en_c   = (state_q == ACTIVE) && (avail_c != '0) && (rd_issued_q < len_q) &&
                    (!ext_valid_q || bus.ext_ready);
      hs_c        = ext_valid_q && bus.ext_ready;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d       = (bus.tile_len > DEPTH_L) ? DEPTH_L : bus.tile_len;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               rd_issued_d = '0;
               state_d     = (bus.tile_len == '0) ? DONE : ACTIVE;
            end
         end
         ACTIVE: begin
            if (store_en_c) wr_ptr_d = wr_ptr_q + ONE;
            if (send_en_c)  rd_issued_d = rd_issued_q + ONE;
            if (hs_c) begin
               rd_ptr_d = rd_ptr_q + ONE;
               if (rd_ptr_q + ONE == len_q) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The registered buffer read lands one cycle after the send strobe, alongside ext_valid.
      if (send_en_c)          ext_valid_d = 1'b1;
      else if (bus.ext_ready) ext_valid_d = 1'b0;
      else                    ext_valid_d = ext_valid_q;

      tile_done_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);

`ifdef OUTPUT_BUFFER_CTRL_STATUS_EN
      proto_err_d = proto_err_q ||
                    (bus.res_valid && ((state_q != ACTIVE) || (wr_ptr_q == len_q)));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_issued_q <= '0;
         len_q       <= '0;
         ext_valid_q <= 1'b0;
         tile_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_issued_q <= rd_issued_d;
         len_q       <= len_d;
         ext_valid_q <= ext_valid_d;
         tile_done_q <= tile_done_d;
         busy_q      <= busy_d;
      end
   end

`ifdef OUTPUT_BUFFER_CTRL_STATUS_EN
   always_ff @(posedge clk) begin
      if (rst) proto_err_q <= 1'b0;
      else     proto_err_q <= proto_err_d;
   end

   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign proto_err = proto_err_q;
`endif

   assign bus.res_ready      = res_ready_c;
   assign bus.buf_store_data = bus.res_data;
   assign bus.buf_store_addr = wr_ptr_q[AW-1:0];
   assign bus.buf_store_en   = store_en_c;
   assign bus.buf_send_addr  = rd_issued_q[AW-1:0];
   assign bus.buf_send_en    = send_en_c;
   assign bus.ext_valid      = ext_valid_q;
   assign bus.ext_data       = bus.buf_res;
   assign bus.busy           = busy_q;
   assign bus.tile_done      = tile_done_q;
endmodule
